// File: rtl/tag_fifo_if.sv
// Free-tag pool handshake bundle: commit-side return, dispatch-side pop, head tag and flags.
// Latency: n/a (wires only); backpressure: consumers qualify Tag_Out with tagFifo_empty.
// master drives requests (core side), slave is the FIFO itself.
interface tag_fifo_if #(
    parameter int TAG_W = 5
);
    logic [TAG_W-1:0] RB_Tag;
    logic             RB_Tag_Valid;
    logic             Rd_en;
    logic [TAG_W-1:0] Tag_Out;
    logic             tagFifo_full;
    logic             tagFifo_empty;

    modport master (
        output RB_Tag, RB_Tag_Valid, Rd_en,
        input  Tag_Out, tagFifo_full, tagFifo_empty
    );

    modport slave (
        input  RB_Tag, RB_Tag_Valid, Rd_en,
        output Tag_Out, tagFifo_full, tagFifo_empty
    );
endinterface

// File: rtl/tag_fifo.sv
// Free-tag pool: circular FIFO of unused ROB/physical tags, preloaded with every tag on reset.
// Latency: zero-cycle read (FWFT head); a pushed tag is visible on Tag_Out the cycle after its edge.
// Backpressure: writes while full are dropped unless a pop frees the slot; reads while empty are ignored.
module tag_fifo #(
    parameter int DEPTH = 32,
    parameter int TAG_W = 5
) (
    input  logic     clock,
    input  logic     reset,
    tag_fifo_if.slave fifo_if
);
    localparam int CNT_W = TAG_W + 1;

    logic [TAG_W-1:0] mem [DEPTH];
    logic [TAG_W-1:0] rd_ptr;
    logic [TAG_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A write into a full pool is legal only when the same-cycle pop frees the head slot.
    assign push = fifo_if.RB_Tag_Valid & (~full | fifo_if.Rd_en);
    assign pop  = fifo_if.Rd_en & ~empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= TAG_W'(i);
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= CNT_W'(DEPTH);
        end else begin
            if (push) begin
                mem[wr_ptr] <= fifo_if.RB_Tag;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Stale entry is shown when empty; the empty flag qualifies it.
    assign fifo_if.Tag_Out       = mem[rd_ptr];
    assign fifo_if.tagFifo_full  = full;
    assign fifo_if.tagFifo_empty = empty;
endmodule

// File: tb/tb_tag_fifo.sv
// Self-checking bench for tag_fifo: directed test-plan sequences plus randomized traffic
// compared against a queue model of the free-tag pool.
module tb_tag_fifo;
    logic clock = 1'b0;
    logic reset;

    tag_fifo_if #(.TAG_W(5)) fifo_if ();

    tag_fifo #(.DEPTH(32), .TAG_W(5)) dut (
        .clock   (clock),
        .reset   (reset),
        .fifo_if (fifo_if)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [4:0] model_q[$];
    bit         model_valid = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, compare outputs with the model, then advance the model.
    task automatic step(input bit rst, input bit vld, input logic [4:0] tag, input bit rd);
        bit do_push;
        bit do_pop;
        @(negedge clock);
        reset                = rst;
        fifo_if.RB_Tag_Valid = vld;
        fifo_if.RB_Tag       = tag;
        fifo_if.Rd_en        = rd;
        #1;
        if (model_valid) begin
            check("full",  int'(fifo_if.tagFifo_full),  int'(model_q.size() == 32));
            check("empty", int'(fifo_if.tagFifo_empty), int'(model_q.size() == 0));
            if (model_q.size() > 0)
                check("tag_out", int'(fifo_if.Tag_Out), int'(model_q[0]));
        end
        if (rst) begin
            model_q.delete();
            for (int i = 0; i < 32; i++) model_q.push_back(5'(i));
            model_valid = 1'b1;
        end else if (model_valid) begin
            do_push = vld && (model_q.size() < 32 || rd);
            do_pop  = rd && (model_q.size() > 0);
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(tag);
        end
    endtask

    initial begin
        reset                = 1'b0;
        fifo_if.RB_Tag_Valid = 1'b0;
        fifo_if.RB_Tag       = '0;
        fifo_if.Rd_en        = 1'b0;

        // Reset, then explicit reset-state values
        step(1'b1, 1'b0, 5'd0, 1'b0);
        @(negedge clock);
        #1;
        check("rst_tag_out", int'(fifo_if.Tag_Out), 0);
        check("rst_full",    int'(fifo_if.tagFifo_full), 1);
        check("rst_empty",   int'(fifo_if.tagFifo_empty), 0);

        // Write while full: all ignored
        for (int i = 0; i <= 32; i++) step(1'b0, 1'b1, 5'(i), 1'b0);

        // Drain past empty
        for (int i = 0; i < 35; i++) step(1'b0, 1'b0, 5'd0, 1'b1);
        check("drain_empty", int'(fifo_if.tagFifo_empty), 1);

        // Simultaneous push/pop starting from empty
        for (int i = 0; i < 35; i++) step(1'b0, 1'b1, 5'(i), 1'b1);
        step(1'b0, 1'b0, 5'd0, 1'b0);

        // Wrap, then full-with-read
        step(1'b1, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 5'd0, 1'b1);
        for (int i = 27; i < 32; i++) step(1'b0, 1'b1, 5'(i), 1'b0);
        for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 5'd0, 1'b1);
        step(1'b1, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 5'(20 + i), 1'b1);
        step(1'b0, 1'b0, 5'd0, 1'b0);

        // Reset mid-stream
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 5'd0, 1'b1);
        step(1'b1, 1'b0, 5'd0, 1'b1);
        @(negedge clock);
        #1;
        check("midrst_tag_out", int'(fifo_if.Tag_Out), 0);
        check("midrst_full",    int'(fifo_if.tagFifo_full), 1);
        for (int i = 0; i < 33; i++) step(1'b0, 1'b0, 5'd0, 1'b1);

        // Randomized traffic with drifting push/pop bias to visit both full and empty
        for (int n = 0; n < 3000; n++) begin
            int bias;
            bias = ((n / 250) % 2 == 0) ? 3 : 7;
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 9) < bias),
                 5'($urandom),
                 ($urandom_range(0, 9) < (10 - bias)));
        end

        reset = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
